// File: rtl/tilelink_uart.sv
// tilelink_uart: TileLink-mapped 8N1 UART with TX/RX FIFOs and a programmable
// bit period (DIVISOR, in clocks per serial bit).
//
// Optional feature macro: TILELINK_UART_RX_EN
//   defined   -> RX synchroniser, RX FSM and RX FIFO are built
//   undefined -> serial_rx is ignored; DATA reads return 0; RX status bits read 0
//
// Ports:
//   clock, reset_in          single clock, asynchronous active-high reset
//   tick_tla_a_*             TileLink A channel (opcode, address, mask, data, valid)
//   bus_tld_d_*              TileLink D channel (opcode, data, valid), one cycle after a hit
//   serial_rx / serial_tx    serial lines, idle high
//   irq                      level interrupt
//
// Register map (index = a_address[3:2]):
//   0 DATA     write pushes TX byte, read pops RX byte
//   1 STATUS   flags and FIFO counts; bits [7:5] are write-1-to-clear
//   2 DIVISOR  clocks per bit, values below 2 are stored as 2
//   3 CTRL     [0] tx_irq_en, [1] rx_irq_en

module tilelink_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

module tilelink_uart #(
  parameter logic [31:0] addr_mask    = 32'hF000_0000,
  parameter logic [31:0] addr_tag     = 32'h4000_0000,
  parameter logic [15:0] clks_per_bit = 16'd16,
  parameter int          fifo_depth   = 8
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic [2:0]  tick_tla_a_opcode,
  input  logic [31:0] tick_tla_a_address,
  input  logic [3:0]  tick_tla_a_mask,
  input  logic [31:0] tick_tla_a_data,
  input  logic        tick_tla_a_valid,
  output logic [2:0]  bus_tld_d_opcode,
  output logic [31:0] bus_tld_d_data,
  output logic        bus_tld_d_valid,
  input  logic        serial_rx,
  output logic        serial_tx,
  output logic        irq
);
  localparam int CW = $clog2(fifo_depth) + 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

  // Bus decode
  logic       hit, wr, rd;
  logic [1:0] idx;
  assign hit = tick_tla_a_valid && ((tick_tla_a_address & addr_mask) == addr_tag);
  assign idx = tick_tla_a_address[3:2];
  assign wr  = hit && (tick_tla_a_opcode == 3'd0 || tick_tla_a_opcode == 3'd1);
  assign rd  = hit && (tick_tla_a_opcode == 3'd4);

  logic [15:0] div_q, div_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        d_valid_q, d_valid_d;
  logic [2:0]  d_opcode_q, d_opcode_d;
  logic [31:0] d_data_q, d_data_d;
  logic        status_w1c;
  assign status_w1c = wr && idx == 2'd1 && tick_tla_a_mask[0];

  // TX FIFO
  logic          tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count;
  assign tx_push = wr && idx == 2'd0 && tick_tla_a_mask[0];

  tilelink_uart_fifo #(.DEPTH(fifo_depth), .WIDTH(8)) u_tx_fifo (
    .clock(clock), .reset_in(reset_in), .push(tx_push), .pop(tx_pop),
    .wdata(tick_tla_a_data[7:0]), .rdata(tx_head), .full(tx_full),
    .empty(tx_empty), .drop(tx_drop), .count(tx_count)
  );

  // TX serialiser
  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_out_q, tx_out_d, tx_busy, tx_last;

  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_last = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_div_d   = div_q;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      TX_DATA: begin
        if (tx_last) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else tx_bit_d = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_cnt_d = '0;
          // Chain straight into the next frame so queued bytes leave without an idle gap.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_div_d   = div_q;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q + 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is registered from the current state, so it trails the FSM by one clock.
    case (tx_state_q)
      TX_START: tx_out_d = 1'b0;
      TX_DATA:  tx_out_d = tx_shift_q[0];
      default:  tx_out_d = 1'b1;
    endcase
  end

  assign serial_tx = tx_out_q;

  // RX path (status view)
  logic          rx_valid, rx_full, rx_ovr, rx_frm;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;

`ifdef TILELINK_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_ovr_q, rx_ovr_d, rx_frm_q, rx_frm_d;
  logic        rx_push, rx_pop, rx_empty, rx_drop, rx_frm_set;

  assign rx_pop = rd && idx == 2'd0;

  tilelink_uart_fifo #(.DEPTH(fifo_depth), .WIDTH(8)) u_rx_fifo (
    .clock(clock), .reset_in(reset_in), .push(rx_push), .pop(rx_pop),
    .wdata(rx_shift_q), .rdata(rx_head), .full(rx_full),
    .empty(rx_empty), .drop(rx_drop), .count(rx_count)
  );

  assign rx_valid = !rx_empty;
  assign rx_ovr   = rx_ovr_q;
  assign rx_frm   = rx_frm_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_frm_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_div_d   = div_q;
        end
      end
      RX_START: begin
        // Mid-start-bit check rejects short glitches on the idle line.
        if (rx_cnt_q == (rx_div_q >> 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = '0;
          rx_push    = rx_s2_q;
          rx_frm_set = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q + 16'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    // A new error in the same cycle as a clear wins, so no event is lost.
    rx_ovr_d = rx_ovr_q;
    rx_frm_d = rx_frm_q;
    if (status_w1c && tick_tla_a_data[6]) rx_ovr_d = 1'b0;
    if (status_w1c && tick_tla_a_data[7]) rx_frm_d = 1'b0;
    if (rx_drop)    rx_ovr_d = 1'b1;
    if (rx_frm_set) rx_frm_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= clks_per_bit;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ovr_q   <= 1'b0;
      rx_frm_q   <= 1'b0;
    end else begin
      rx_s1_q    <= serial_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_frm_q   <= rx_frm_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{tick_tla_a_data[31:16], tick_tla_a_mask[3:2]};
`else
  assign rx_valid = 1'b0;
  assign rx_full  = 1'b0;
  assign rx_ovr   = 1'b0;
  assign rx_frm   = 1'b0;
  assign rx_head  = 8'd0;
  assign rx_count = '0;

  logic unused_ok;
  assign unused_ok = ^{tick_tla_a_data[31:16], tick_tla_a_mask[3:2], serial_rx};
`endif

  // Register file, read mux and response
  logic [31:0] status, rdata;
  assign status = {8'd0, 8'(rx_count), 8'(tx_count), rx_frm, rx_ovr, tx_ovf_q,
                   tx_busy, rx_full, rx_valid, tx_empty, tx_full};

  always_comb begin
    case (idx)
      2'd0:    rdata = rx_valid ? {24'd0, rx_head} : 32'd0;
      2'd1:    rdata = status;
      2'd2:    rdata = {16'd0, div_q};
      default: rdata = {30'd0, ctrl_q};
    endcase
    d_valid_d  = hit;
    d_opcode_d = rd ? 3'd1 : 3'd0;
    d_data_d   = rd ? rdata : 32'd0;

    div_d = div_q;
    if (wr && idx == 2'd2) begin
      if (tick_tla_a_mask[0]) div_d[7:0]  = tick_tla_a_data[7:0];
      if (tick_tla_a_mask[1]) div_d[15:8] = tick_tla_a_data[15:8];
      div_d = clamp_div(div_d);
    end
    ctrl_d = ctrl_q;
    if (wr && idx == 2'd3 && tick_tla_a_mask[0]) ctrl_d = tick_tla_a_data[1:0];
    tx_ovf_d = tx_ovf_q;
    if (status_w1c && tick_tla_a_data[5]) tx_ovf_d = 1'b0;
    if (tx_drop) tx_ovf_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      div_q      <= clks_per_bit;
      ctrl_q     <= '0;
      tx_ovf_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      d_opcode_q <= '0;
      d_data_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= clks_per_bit;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
    end else begin
      div_q      <= div_d;
      ctrl_q     <= ctrl_d;
      tx_ovf_q   <= tx_ovf_d;
      d_valid_q  <= d_valid_d;
      d_opcode_q <= d_opcode_d;
      d_data_q   <= d_data_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
    end
  end

  assign bus_tld_d_valid  = d_valid_q;
  assign bus_tld_d_opcode = d_opcode_q;
  assign bus_tld_d_data   = d_data_q;
  assign irq = (ctrl_q[0] & tx_empty & ~tx_busy) | (ctrl_q[1] & rx_valid);
endmodule

// File: tb/tb_tilelink_uart.sv
// Directed-sequence bench for tilelink_uart with randomized bytes and divisors.
// Expected values come from a frame/queue model of the UART behaviour.
module tb_tilelink_uart;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clock = 1'b0;
  logic        reset_in = 1'b1;
  logic [2:0]  a_opcode = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        a_valid = 1'b0;
  logic [2:0]  d_opcode;
  logic [31:0] d_data;
  logic        d_valid;
  logic        serial_rx = 1'b1;
  logic        serial_tx;
  logic        irq;

  always #5 clock = ~clock;

  tilelink_uart #(
    .addr_mask(32'hF000_0000), .addr_tag(BASE),
    .clks_per_bit(16'd16), .fifo_depth(DEPTH)
  ) dut (
    .clock(clock), .reset_in(reset_in),
    .tick_tla_a_opcode(a_opcode), .tick_tla_a_address(a_address),
    .tick_tla_a_mask(a_mask), .tick_tla_a_data(a_data), .tick_tla_a_valid(a_valid),
    .bus_tld_d_opcode(d_opcode), .bus_tld_d_data(d_data), .bus_tld_d_valid(d_valid),
    .serial_rx(serial_rx), .serial_tx(serial_tx), .irq(irq)
  );

  int n_total = 0;
  int n_pass  = 0;
  byte unsigned rx_model[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Status word assembled from model quantities.
  function automatic logic [31:0] exp_status(int txc, int rxc, bit busy, bit ovf, bit ovr, bit frm);
    logic [31:0] s;
    s        = '0;
    s[0]     = (txc == DEPTH);
    s[1]     = (txc == 0);
    s[2]     = (rxc > 0);
    s[3]     = (rxc == DEPTH);
    s[4]     = busy;
    s[5]     = ovf;
    s[6]     = ovr;
    s[7]     = frm;
    s[15:8]  = 8'(txc);
    s[23:16] = 8'(rxc);
    return s;
  endfunction

  task automatic bus(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, output logic vld, output logic [2:0] dop,
                     output logic [31:0] rdat);
    @(negedge clock);
    a_opcode = op; a_address = addr; a_mask = mask; a_data = data; a_valid = 1'b1;
    @(negedge clock);
    a_valid = 1'b0;
    vld = d_valid; dop = d_opcode; rdat = d_data;
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] data);
    logic v; logic [2:0] o; logic [31:0] r; logic [31:0] addr;
    addr = BASE; addr[3:2] = idx;
    bus(3'd1, addr, 4'hF, data, v, o, r);
    chk("write_ack", {v, o, r}, {1'b1, 3'd0, 32'd0});
  endtask

  task automatic rd_reg(input logic [1:0] idx, output logic [31:0] data);
    logic v; logic [2:0] o; logic [31:0] addr;
    addr = BASE; addr[3:2] = idx;
    bus(3'd4, addr, 4'hF, 32'd0, v, o, data);
    chk("read_ack", {v, o}, {1'b1, 3'd1});
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    rd_reg(idx, r);
    chk(tag, r, exp);
  endtask

  // Write one byte and follow serial_tx: start bit begins 2 clocks after the write edge.
  task automatic tx_frame_check(input logic [7:0] b, input int div);
    logic e;
    int t;
    wr_reg(2'd0, {24'd0, b});
    for (int k = 0; k < 2 + 10 * div + 2; k++) begin
      if (k < 2) e = 1'b1;
      else begin
        t = (k - 2) / div;
        if (t == 0) e = 1'b0;
        else if (t <= 8) e = b[t-1];
        else e = 1'b1;
      end
      chk("tx_line", serial_tx, e);
      @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    serial_rx = 1'b0;
    repeat (div) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      repeat (div) @(negedge clock);
    end
    serial_rx = stop;
    repeat (div) @(negedge clock);
    serial_rx = 1'b1;
    repeat (2 * div) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v; logic [2:0] o; logic [31:0] r;
    logic [7:0] b;
    int div;

    // Reset state
    #12;
    chk("rst_tx", serial_tx, 1'b1);
    chk("rst_irq", irq, 1'b0);
    chk("rst_dvalid", d_valid, 1'b0);
    chk("rst_ddata", d_data, 32'd0);
    @(negedge clock);
    reset_in = 1'b0;
    rd_chk("rst_status", 2'd1, exp_status(0, 0, 0, 0, 0, 0));
    rd_chk("rst_div", 2'd2, 32'd16);
    rd_chk("rst_ctrl", 2'd3, 32'd0);
    rd_chk("empty_data", 2'd0, 32'd0);

    // DIVISOR clamp and byte masks; address decode
    wr_reg(2'd2, 32'd0);
    rd_chk("div_zero", 2'd2, 32'd2);
    wr_reg(2'd2, 32'd1);
    rd_chk("div_one", 2'd2, 32'd2);
    bus(3'd1, BASE | 32'h8, 4'b0001, 32'h0000_1234, v, o, r);
    rd_chk("div_mask", 2'd2, 32'h34);
    bus(3'd4, 32'h5000_0000, 4'hF, 32'd0, v, o, r);
    chk("nohit_read", v, 1'b0);
    bus(3'd1, 32'h5000_0000, 4'hF, 32'hAA, v, o, r);
    chk("nohit_write", v, 1'b0);
    bus(3'd1, BASE, 4'b1110, 32'hAA, v, o, r);
    rd_chk("nohit_status", 2'd1, exp_status(0, 0, 0, 0, 0, 0));

    // TX frames
    wr_reg(2'd2, 32'd4);
    tx_frame_check(8'h55, 4);
    for (int n = 0; n < 2; n++) begin
      div = $urandom_range(2, 7);
      b = 8'($urandom);
      wr_reg(2'd2, 32'(div));
      tx_frame_check(b, div);
    end
    rd_chk("tx_done_status", 2'd1, exp_status(0, 0, 0, 0, 0, 0));

    // TX interrupt and busy
    wr_reg(2'd3, 32'd1);
    chk("tx_irq_idle", irq, 1'b1);
    wr_reg(2'd0, $urandom & 32'hFF);
    rd_chk("tx_busy_status", 2'd1, exp_status(0, 0, 1, 0, 0, 0));
    chk("tx_irq_busy", irq, 1'b0);
    repeat (80) @(negedge clock);
    rd_chk("tx_idle_status", 2'd1, exp_status(0, 0, 0, 0, 0, 0));
    chk("tx_irq_again", irq, 1'b1);
    wr_reg(2'd3, 32'd0);

    // TX FIFO overflow with transmitter stalled on a very long bit period
    wr_reg(2'd2, 32'hFFFF);
    wr_reg(2'd0, $urandom & 32'hFF);
    for (int n = 0; n < DEPTH + 1; n++) wr_reg(2'd0, $urandom & 32'hFF);
    rd_chk("tx_ovf_status", 2'd1, exp_status(DEPTH, 0, 1, 1, 0, 0));
    wr_reg(2'd1, 32'h20);
    rd_chk("tx_ovf_clear", 2'd1, exp_status(DEPTH, 0, 1, 0, 0, 0));

    // Reset mid-frame
    chk("tx_start_low", serial_tx, 1'b0);
    #2 reset_in = 1'b1;
    #1;
    chk("rst_async_tx", serial_tx, 1'b1);
    chk("rst_async_dvalid", d_valid, 1'b0);
    @(negedge clock);
    reset_in = 1'b0;
    rd_chk("rst_mid_status", 2'd1, exp_status(0, 0, 0, 0, 0, 0));
    rd_chk("rst_mid_div", 2'd2, 32'd16);

`ifdef TILELINK_UART_RX_EN
    wr_reg(2'd2, 32'd8);
    wr_reg(2'd3, 32'd2);
    chk("rx_irq_none", irq, 1'b0);
    send_frame(8'hA3, 1'b1, 8);
    rx_model.push_back(8'hA3);
    rd_chk("rx_one_status", 2'd1, exp_status(0, rx_model.size(), 0, 0, 0, 0));
    chk("rx_irq_set", irq, 1'b1);
    rd_chk("rx_a3", 2'd0, {24'd0, rx_model.pop_front()});
    rd_chk("rx_drained", 2'd1, exp_status(0, 0, 0, 0, 0, 0));
    chk("rx_irq_clr", irq, 1'b0);

    for (int n = 0; n < 3; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 8);
      rx_model.push_back(b);
    end
    rd_chk("rx_three_status", 2'd1, exp_status(0, rx_model.size(), 0, 0, 0, 0));
    for (int n = 0; n < 3; n++) rd_chk("rx_rand_byte", 2'd0, {24'd0, rx_model.pop_front()});

    send_frame(8'($urandom), 1'b0, 8);
    rd_chk("rx_frm_status", 2'd1, exp_status(0, 0, 0, 0, 0, 1));
    wr_reg(2'd1, 32'h80);
    rd_chk("rx_frm_clear", 2'd1, exp_status(0, 0, 0, 0, 0, 0));

    serial_rx = 1'b0;
    repeat (2) @(negedge clock);
    serial_rx = 1'b1;
    repeat (30) @(negedge clock);
    rd_chk("rx_glitch", 2'd1, exp_status(0, 0, 0, 0, 0, 0));

    for (int n = 0; n < DEPTH + 1; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, 8);
      if (rx_model.size() < DEPTH) rx_model.push_back(b);
    end
    rd_chk("rx_ovr_status", 2'd1, exp_status(0, DEPTH, 0, 0, 1, 0));
    for (int n = 0; n < DEPTH; n++) rd_chk("rx_fifo_byte", 2'd0, {24'd0, rx_model.pop_front()});
    rd_chk("rx_empty_read", 2'd0, 32'd0);
    wr_reg(2'd1, 32'h40);
    rd_chk("rx_ovr_clear", 2'd1, exp_status(0, 0, 0, 0, 0, 0));
`else
    wr_reg(2'd2, 32'd8);
    wr_reg(2'd3, 32'd2);
    send_frame(8'hA3, 1'b1, 8);
    chk("norx_irq", irq, 1'b0);
    rd_chk("norx_status", 2'd1, exp_status(0, 0, 0, 0, 0, 0));
    rd_chk("norx_data", 2'd0, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
